block_scheduler: RTL and testbench
==================================

BLOCK_SCHEDULER -- requirements
Module: block_scheduler

Interface
REQ-001 The block SHALL have one clock, clk; reset rst SHALL be asynchronous and active-low.
REQ-002 Port: clk  input  1  system clock, all state on rising edge.
REQ-003 Port: rst  input  1  asynchronous active-low reset.
REQ-004 Port: cfg_we  input  1  loads cfg_blocks into the block-count register; honoured only in IDLE.
REQ-005 Port: cfg_blocks  input  24  number of 8x8 blocks per frame.
REQ-006 Port: start  input  1  single-cycle frame start; honoured only in IDLE.
REQ-007 Port: abort  input  1  synchronous frame abort.
REQ-008 Port: rd_go / dct_go / enc_go  output  1 each  one-cycle stage start pulses.
REQ-009 Port: rd_done / dct_done / enc_done  input  1 each  one-cycle stage completion pulses.
REQ-010 Port: rd_buf / dct_buf  output  1 each  input ping-pong buffer index for the read and DCT stages.
REQ-011 Port: busy  output  1  high while in RUN.
REQ-012 Port: frame_done / aborted  output  1 each  one-cycle status pulses.
REQ-013 Port: blocks_done  output  24  count of blocks encoded in the current frame.
REQ-014 Port: err_spurious  output  1  sticky flag: a done pulse arrived for an inactive stage.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and FIN; FIN SHALL last one cycle and SHALL then return to IDLE.
REQ-016 Internal state SHALL be: nblk (24b), rd_cnt and enc_cnt (24b), in_full[1:0], coef_full, rd_ptr, dct_ptr, and active flags rd_act, dct_act and enc_act.
REQ-017 All outputs SHALL be registered; each *_go SHALL be high for exactly one cycle per issue.
REQ-018 start in IDLE with nblk>0 SHALL clear all counters, flags and pointers, SHALL enter RUN and SHALL assert rd_go with rd_buf=0 at the same edge.
REQ-019 start in IDLE with nblk=0 SHALL enter FIN, SHALL issue no go pulse and SHALL pulse frame_done one cycle later.
REQ-020 In RUN, rd_go SHALL be issued when !rd_act and rd_cnt<nblk and !in_full[rd_ptr]; the same edge SHALL set rd_act, increment rd_cnt and present rd_buf=rd_ptr.
REQ-021 Sampled rd_done with rd_act SHALL set in_full[rd_ptr], toggle rd_ptr and clear rd_act.
REQ-022 dct_go SHALL be issued when !dct_act and in_full[dct_ptr] and !coef_full; it SHALL set dct_act, with dct_buf=dct_ptr.
REQ-023 Sampled dct_done with dct_act SHALL clear in_full[dct_ptr], toggle dct_ptr, set coef_full and clear dct_act.
REQ-024 enc_go SHALL be issued when !enc_act and coef_full; it SHALL set enc_act.
REQ-025 Sampled enc_done with enc_act SHALL clear coef_full, clear enc_act and increment enc_cnt.
REQ-026 Issue conditions SHALL use registered state only; a stage SHALL be re-issued no earlier than the edge after its done is sampled.
REQ-027 Simultaneous done pulses on different stages SHALL all be applied in the same edge with no loss; in_full set and clear SHALL act on distinct bits.
REQ-028 A done pulse with the corresponding *_act low SHALL be ignored and SHALL set err_spurious.
REQ-029 When enc_cnt reaches nblk, the block SHALL enter FIN; frame_done SHALL pulse in the FIN cycle and busy SHALL drop.
REQ-030 blocks_done SHALL equal enc_cnt and SHALL hold its value in IDLE until the next accepted start.
REQ-031 abort in RUN SHALL return to IDLE at the next edge, SHALL clear flags, active bits and go outputs, SHALL pulse aborted and SHALL NOT pulse frame_done.
REQ-032 abort outside RUN SHALL be ignored; cfg_we and start SHALL be ignored outside IDLE.
REQ-033 err_spurious SHALL clear only on reset or on an accepted start.

Reset
REQ-034 On rst low, the block SHALL immediately enter IDLE and all outputs SHALL go to 0; nblk SHALL reset to 0.
REQ-035 Reset mid-frame SHALL discard all progress; no frame_done or aborted pulse SHALL occur.

Verification
REQ-036 cfg_blocks=1, start, each stage answering done 3 cycles after its go -> go order rd,dct,enc once each, frame_done once, blocks_done=1, busy low after.
REQ-037 cfg_blocks=4, slow encoder (done 70 cycles after go) -> rd_buf sequence 0,1,0,1; at most two blocks read ahead of DCT; blocks_done=4.
REQ-038 cfg_blocks=0, start -> no go pulses, frame_done 2 cycles after start.
REQ-039 Frame of 3 blocks with abort asserted during the second read -> aborted pulse, busy low next cycle, no frame_done, and a subsequent start runs cleanly.
REQ-040 dct_done pulsed while dct_act is low -> err_spurious=1, state unchanged; err_spurious clears on the next start.
REQ-041 rst low mid-frame -> all outputs 0 asynchronously; cfg_we with cfg_blocks=5 then start -> 5 blocks completed.

Source files
------------

// File: rtl/block_scheduler_if.sv
// ----------------------------------------------------------------------------
// block_scheduler_if
//   Control/status bundle between a frame controller and the block scheduler.
//   master : frame controller side (drives config, start/abort, stage dones)
//   slave  : scheduler side (drives stage go pulses, buffer indices, status)
//
//   cfg_we, cfg_blocks[23:0]   block-count load (honoured in IDLE only)
//   start, abort               frame start / abort pulses
//   rd_go,  dct_go,  enc_go    one-cycle stage start pulses
//   rd_done,dct_done,enc_done  one-cycle stage completion pulses
//   rd_buf, dct_buf            ping-pong input buffer index per stage
//   busy, frame_done, aborted  frame status
//   blocks_done[23:0]          blocks encoded in the current frame
//   err_spurious               sticky: done arrived for an idle stage
// ----------------------------------------------------------------------------
interface block_scheduler_if;
   logic        cfg_we;
   logic [23:0] cfg_blocks;
   logic        start;
   logic        abort;
   logic        rd_go;
   logic        dct_go;
   logic        enc_go;
   logic        rd_done;
   logic        dct_done;
   logic        enc_done;
   logic        rd_buf;
   logic        dct_buf;
   logic        busy;
   logic        frame_done;
   logic        aborted;
   logic [23:0] blocks_done;
   logic        err_spurious;

   modport master (
      output cfg_we, cfg_blocks, start, abort, rd_done, dct_done, enc_done,
      input  rd_go, dct_go, enc_go, rd_buf, dct_buf, busy, frame_done,
             aborted, blocks_done, err_spurious
   );

   modport slave (
      input  cfg_we, cfg_blocks, start, abort, rd_done, dct_done, enc_done,
      output rd_go, dct_go, enc_go, rd_buf, dct_buf, busy, frame_done,
             aborted, blocks_done, err_spurious
   );
endinterface

// File: rtl/block_scheduler.sv
// ----------------------------------------------------------------------------
// block_scheduler
//   Sequences a three-stage pipeline (read -> DCT -> encode) over the 8x8
//   blocks of one frame. Reads fill a two-entry ping-pong input buffer, the
//   DCT drains it into a single coefficient slot, the encoder drains that.
//   Each stage is started with a one-cycle go pulse and reports back with a
//   one-cycle done pulse. All outputs are registered.
//
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : block_scheduler_if.slave (config, start/abort, go/done, status)
// ----------------------------------------------------------------------------
module block_scheduler (
   input  logic             clk,
   input  logic             rst,
   block_scheduler_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t      state_q, state_d;
   logic [23:0] nblk_q, nblk_d;
   logic [23:0] rd_cnt_q, rd_cnt_d;
   logic [23:0] enc_cnt_q, enc_cnt_d;
   logic [23:0] enc_cnt_inc;
   logic [1:0]  in_full_q, in_full_d;
   logic        coef_full_q, coef_full_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        dct_ptr_q, dct_ptr_d;
   logic        rd_act_q, rd_act_d;
   logic        dct_act_q, dct_act_d;
   logic        enc_act_q, enc_act_d;

   logic        rd_go_q, rd_go_d;
   logic        dct_go_q, dct_go_d;
   logic        enc_go_q, enc_go_d;
   logic        rd_buf_q, rd_buf_d;
   logic        dct_buf_q, dct_buf_d;
   logic        busy_q, busy_d;
   logic        frame_done_q, frame_done_d;
   logic        aborted_q, aborted_d;
   logic        err_q, err_d;

   logic        rd_ok, dct_ok, enc_ok;
   logic        rd_issue, dct_issue, enc_issue;

   // A done only counts while its stage is active.
   assign rd_ok  = bus.rd_done  & rd_act_q;
   assign dct_ok = bus.dct_done & dct_act_q;
   assign enc_ok = bus.enc_done & enc_act_q;

   // Issue tests look at registered state only, so a stage whose done is
   // sampled at one edge cannot be restarted before the following edge.
   assign rd_issue  = !rd_act_q && (rd_cnt_q < nblk_q) && !in_full_q[rd_ptr_q];
   assign dct_issue = !dct_act_q && in_full_q[dct_ptr_q] && !coef_full_q;
   assign enc_issue = !enc_act_q && coef_full_q;

   assign enc_cnt_inc = enc_cnt_q + 24'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         nblk_q       <= '0;
         rd_cnt_q     <= '0;
         enc_cnt_q    <= '0;
         in_full_q    <= '0;
         coef_full_q  <= 1'b0;
         rd_ptr_q     <= 1'b0;
         dct_ptr_q    <= 1'b0;
         rd_act_q     <= 1'b0;
         dct_act_q    <= 1'b0;
         enc_act_q    <= 1'b0;
         rd_go_q      <= 1'b0;
         dct_go_q     <= 1'b0;
         enc_go_q     <= 1'b0;
         rd_buf_q     <= 1'b0;
         dct_buf_q    <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         aborted_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         nblk_q       <= nblk_d;
         rd_cnt_q     <= rd_cnt_d;
         enc_cnt_q    <= enc_cnt_d;
         in_full_q    <= in_full_d;
         coef_full_q  <= coef_full_d;
         rd_ptr_q     <= rd_ptr_d;
         dct_ptr_q    <= dct_ptr_d;
         rd_act_q     <= rd_act_d;
         dct_act_q    <= dct_act_d;
         enc_act_q    <= enc_act_d;
         rd_go_q      <= rd_go_d;
         dct_go_q     <= dct_go_d;
         enc_go_q     <= enc_go_d;
         rd_buf_q     <= rd_buf_d;
         dct_buf_q    <= dct_buf_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         aborted_q    <= aborted_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      nblk_d       = nblk_q;
      rd_cnt_d     = rd_cnt_q;
      enc_cnt_d    = enc_cnt_q;
      in_full_d    = in_full_q;
      coef_full_d  = coef_full_q;
      rd_ptr_d     = rd_ptr_q;
      dct_ptr_d    = dct_ptr_q;
      rd_act_d     = rd_act_q;
      dct_act_d    = dct_act_q;
      enc_act_d    = enc_act_q;
      rd_go_d      = 1'b0;
      dct_go_d     = 1'b0;
      enc_go_d     = 1'b0;
      rd_buf_d     = rd_buf_q;
      dct_buf_d    = dct_buf_q;
      busy_d       = 1'b0;
      frame_done_d = 1'b0;
      aborted_d    = 1'b0;
      err_d        = err_q;

      if ((bus.rd_done && !rd_act_q) || (bus.dct_done && !dct_act_q) ||
          (bus.enc_done && !enc_act_q))
         err_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (bus.cfg_we)
               nblk_d = bus.cfg_blocks;
            if (bus.start) begin
               rd_cnt_d    = '0;
               enc_cnt_d   = '0;
               in_full_d   = '0;
               coef_full_d = 1'b0;
               rd_ptr_d    = 1'b0;
               dct_ptr_d   = 1'b0;
               rd_act_d    = 1'b0;
               dct_act_d   = 1'b0;
               enc_act_d   = 1'b0;
               err_d       = 1'b0;
               if (nblk_q != '0) begin
                  // First read is launched on the accepting edge itself.
                  state_d  = RUN;
                  busy_d   = 1'b1;
                  rd_go_d  = 1'b1;
                  rd_buf_d = 1'b0;
                  rd_act_d = 1'b1;
                  rd_cnt_d = 24'd1;
               end else begin
                  state_d = FIN;
               end
            end
         end

         RUN: begin
            if (bus.abort) begin
               state_d     = IDLE;
               in_full_d   = '0;
               coef_full_d = 1'b0;
               rd_act_d    = 1'b0;
               dct_act_d   = 1'b0;
               enc_act_d   = 1'b0;
               aborted_d   = 1'b1;
            end else begin
               busy_d = 1'b1;

               // rd sets in_full[rd_ptr] while dct clears in_full[dct_ptr];
               // an in-flight read always targets an empty buffer and an
               // in-flight DCT a full one, so the two bits never coincide.
               if (rd_ok) begin
                  in_full_d[rd_ptr_q] = 1'b1;
                  rd_ptr_d            = ~rd_ptr_q;
                  rd_act_d            = 1'b0;
               end
               if (enc_ok) begin
                  coef_full_d = 1'b0;
                  enc_act_d   = 1'b0;
                  enc_cnt_d   = enc_cnt_inc;
               end
               if (dct_ok) begin
                  in_full_d[dct_ptr_q] = 1'b0;
                  dct_ptr_d            = ~dct_ptr_q;
                  coef_full_d          = 1'b1;
                  dct_act_d            = 1'b0;
               end

               if (rd_issue) begin
                  rd_go_d  = 1'b1;
                  rd_act_d = 1'b1;
                  rd_cnt_d = rd_cnt_q + 24'd1;
                  rd_buf_d = rd_ptr_q;
               end
               if (dct_issue) begin
                  dct_go_d  = 1'b1;
                  dct_act_d = 1'b1;
                  dct_buf_d = dct_ptr_q;
               end
               if (enc_issue) begin
                  enc_go_d  = 1'b1;
                  enc_act_d = 1'b1;
               end

               if (enc_ok && (enc_cnt_inc == nblk_q)) begin
                  state_d = FIN;
                  busy_d  = 1'b0;
               end
            end
         end

         FIN: begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.rd_go        = rd_go_q;
   assign bus.dct_go       = dct_go_q;
   assign bus.enc_go       = enc_go_q;
   assign bus.rd_buf       = rd_buf_q;
   assign bus.dct_buf      = dct_buf_q;
   assign bus.busy         = busy_q;
   assign bus.frame_done   = frame_done_q;
   assign bus.aborted      = aborted_q;
   assign bus.blocks_done  = enc_cnt_q;
   assign bus.err_spurious = err_q;

endmodule

// File: tb/tb_block_scheduler.sv
// ----------------------------------------------------------------------------
// tb_block_scheduler
//   Drives block_scheduler through its interface with directed and random
//   frames. Stage responders answer each go with a done after a chosen
//   latency. A counter-based model (blocks issued/finished per stage, buffer
//   occupancy derived from those counts) predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_block_scheduler;

   logic clk;
   logic rst;

   block_scheduler_if bus ();

   block_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // model state: phase 0=idle 1=run 2=fin
   int ph, n_cfg, n_run;
   int rd_iss, rd_dn, dct_iss, dct_dn, enc_iss, enc_dn;
   int t_rd, t_dct, t_enc;
   int lat_rd, lat_dct, lat_enc;

   logic        e_rd_go, e_dct_go, e_enc_go, e_rdbuf, e_dctbuf;
   logic        e_busy, e_fd, e_ab, e_err;
   logic [23:0] e_blocks;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_eq("rd_go",        32'(bus.rd_go),        32'(e_rd_go));
      check_eq("dct_go",       32'(bus.dct_go),       32'(e_dct_go));
      check_eq("enc_go",       32'(bus.enc_go),       32'(e_enc_go));
      check_eq("rd_buf",       32'(bus.rd_buf),       32'(e_rdbuf));
      check_eq("dct_buf",      32'(bus.dct_buf),      32'(e_dctbuf));
      check_eq("busy",         32'(bus.busy),         32'(e_busy));
      check_eq("frame_done",   32'(bus.frame_done),   32'(e_fd));
      check_eq("aborted",      32'(bus.aborted),      32'(e_ab));
      check_eq("blocks_done",  32'(bus.blocks_done),  32'(e_blocks));
      check_eq("err_spurious", 32'(bus.err_spurious), 32'(e_err));
   endtask

   task automatic reset_model();
      ph = 0; n_cfg = 0; n_run = 0;
      rd_iss = 0; rd_dn = 0; dct_iss = 0; dct_dn = 0; enc_iss = 0; enc_dn = 0;
      t_rd = 0; t_dct = 0; t_enc = 0;
      e_rd_go = 0; e_dct_go = 0; e_enc_go = 0; e_rdbuf = 0; e_dctbuf = 0;
      e_busy = 0; e_fd = 0; e_ab = 0; e_err = 0; e_blocks = '0;
   endtask

   task automatic zero_inputs();
      bus.cfg_we = 0; bus.cfg_blocks = '0; bus.start = 0; bus.abort = 0;
      bus.rd_done = 0; bus.dct_done = 0; bus.enc_done = 0;
   endtask

   // One clock cycle: drive inputs, predict, clock, compare, react to gos.
   task automatic tick(input logic st, input logic ab, input logic we,
                       input logic [23:0] cb, input logic sp_rd,
                       input logic sp_dct, input logic sp_enc);
      logic d_rd, d_dct, d_enc, v_rd, v_dct, v_enc;
      logic el_rd, el_dct, el_enc;
      d_rd  = (t_rd == 1)  || (sp_rd  && t_rd == 0);
      d_dct = (t_dct == 1) || (sp_dct && t_dct == 0);
      d_enc = (t_enc == 1) || (sp_enc && t_enc == 0);
      if (t_rd  > 0) t_rd--;
      if (t_dct > 0) t_dct--;
      if (t_enc > 0) t_enc--;
      bus.start = st; bus.abort = ab; bus.cfg_we = we; bus.cfg_blocks = cb;
      bus.rd_done = d_rd; bus.dct_done = d_dct; bus.enc_done = d_enc;

      v_rd  = d_rd  && (rd_iss  > rd_dn);
      v_dct = d_dct && (dct_iss > dct_dn);
      v_enc = d_enc && (enc_iss > enc_dn);
      e_rd_go = 0; e_dct_go = 0; e_enc_go = 0; e_fd = 0; e_ab = 0;
      if ((d_rd && !v_rd) || (d_dct && !v_dct) || (d_enc && !v_enc)) e_err = 1;
      case (ph)
         0: begin
            if (st) begin
               e_err = 0; e_blocks = '0; n_run = n_cfg;
               rd_iss = 0; rd_dn = 0; dct_iss = 0; dct_dn = 0; enc_iss = 0; enc_dn = 0;
               if (n_run > 0) begin
                  ph = 1; e_rd_go = 1; e_rdbuf = 0; rd_iss = 1; e_busy = 1;
               end else begin
                  ph = 2;
               end
            end
            if (we) n_cfg = int'(cb);
         end
         1: begin
            if (ab) begin
               ph = 0; e_ab = 1; e_busy = 0;
            end else begin
               // eligibility from counts before this edge
               el_rd  = (rd_iss == rd_dn) && (rd_iss < n_run) && (rd_dn - dct_dn < 2);
               el_dct = (dct_iss == dct_dn) && (rd_dn > dct_dn) && (dct_dn == enc_dn);
               el_enc = (enc_iss == enc_dn) && (dct_dn > enc_dn);
               if (v_rd)  rd_dn++;
               if (v_dct) dct_dn++;
               if (v_enc) enc_dn++;
               if (el_rd)  begin e_rd_go = 1;  e_rdbuf = rd_iss[0];   rd_iss++;  end
               if (el_dct) begin e_dct_go = 1; e_dctbuf = dct_iss[0]; dct_iss++; end
               if (el_enc) begin e_enc_go = 1; enc_iss++; end
               e_blocks = 24'(enc_dn);
               if (enc_dn == n_run) begin ph = 2; e_busy = 0; end
            end
         end
         default: begin
            ph = 0; e_fd = 1;
         end
      endcase

      @(posedge clk); #1;
      check_outputs();
      if (e_ab) begin t_rd = 0; t_dct = 0; t_enc = 0; end
      if (bus.rd_go)  t_rd  = lat_rd;
      if (bus.dct_go) t_dct = lat_dct;
      if (bus.enc_go) t_enc = lat_enc;
   endtask

   task automatic idle_tick();
      tick(0, 0, 0, '0, 0, 0, 0);
   endtask

   // noise: 0 none, 1 ignored start/cfg/spurious, 2 also random abort
   task automatic run_frame(input int n, input int lr, input int ld,
                            input int le, input int noise);
      int r;
      lat_rd = lr; lat_dct = ld; lat_enc = le;
      tick(0, 0, 1, 24'(n), 0, 0, 0);
      tick(1, 0, 0, '0, 0, 0, 0);
      for (int c = 0; c < 4000 && ph != 0; c++) begin
         r = (noise > 0) ? int'($urandom_range(0, 39)) : 99;
         tick(r == 0, (noise > 1) && (r == 5), r == 1, 24'($urandom_range(0, 9)),
              r == 2, r == 3, r == 4);
      end
      check_eq("frame_back_to_idle", 32'(ph), 32'd0);
      idle_tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c;
      rst = 0;
      zero_inputs();
      reset_model();
      lat_rd = 3; lat_dct = 3; lat_enc = 3;
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      rst = 1;
      idle_tick();

      // single block, every stage answers 3 cycles after its go
      run_frame(1, 3, 3, 3, 0);
      // four blocks with a slow encoder: reads run ahead by at most two
      run_frame(4, 2, 2, 70, 0);
      // empty frame: straight to FIN, frame_done two cycles after start
      run_frame(0, 3, 3, 3, 0);

      // abort during the second read, then a clean frame
      lat_rd = 6; lat_dct = 2; lat_enc = 2;
      tick(0, 0, 1, 24'd3, 0, 0, 0);
      tick(1, 0, 0, '0, 0, 0, 0);
      c = 0;
      while (rd_iss < 2 && c < 200) begin idle_tick(); c++; end
      check_eq("second_read_issued", 32'(rd_iss), 32'd2);
      tick(0, 1, 0, '0, 0, 0, 0);
      idle_tick();
      tick(0, 1, 0, '0, 0, 0, 0);   // abort in IDLE is ignored
      run_frame(3, 2, 2, 2, 0);

      // spurious dct_done while idle sets the sticky flag; start clears it
      tick(0, 0, 0, '0, 0, 1, 0);
      idle_tick();
      run_frame(2, 1, 1, 1, 0);

      // asynchronous reset mid-frame
      lat_rd = 2; lat_dct = 2; lat_enc = 2;
      tick(0, 0, 1, 24'd5, 0, 0, 0);
      tick(1, 0, 0, '0, 0, 0, 0);
      repeat (9) idle_tick();
      #3;
      rst = 0;
      #1;
      reset_model();
      check_outputs();
      zero_inputs();
      @(posedge clk); @(posedge clk); #1;
      check_outputs();
      rst = 1;
      run_frame(5, 2, 3, 1, 0);

      // random frames with ignored control noise, spurious dones and aborts
      for (int f = 0; f < 10; f++)
         run_frame(int'($urandom_range(1, 8)), int'($urandom_range(1, 6)),
                   int'($urandom_range(1, 6)), int'($urandom_range(1, 12)),
                   (f >= 6) ? 2 : 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
